// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM with memory timeout and illegal-op trap
// Define CTRL_PERF_EN to build the retired-instruction counter; otherwise retired is tied to 0.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TMO_W       = 4,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instruction,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_in,
   output logic             ir_we,
   output logic [1:0]       pc_we,
   output logic [1:0]       pc_src,
   output logic             reg_we,
   output logic [1:0]       dst,
   output logic [1:0]       reg_in,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [3:0]       state,
   output logic [1:0]       fault,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EX_R   = 4'd2,
      S_EX_I   = 4'd3,
      S_EX_M   = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_EX_BR  = 4'd7,
      S_JMP    = 4'd8,
      S_WB_R   = 4'd9,
      S_WB_I   = 4'd10,
      S_WB_LW  = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
   localparam logic [1:0] FAULT_TMO     = 2'd2;

   // The wait counter stops one short of MEM_TIMEOUT: that cycle without an ack is the trap cycle.
   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [1:0]       fault_q, fault_d;
   logic [TMO_W-1:0] wait_q;
   logic [5:0]       opcode, funct;
   logic             in_mem, enter_mem, tmo_hit;
   logic             unused_instr;

   assign opcode       = instruction[31:26];
   assign funct        = instruction[5:0];
   assign unused_instr = ^instruction[25:6];

   assign in_mem    = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   assign enter_mem = (state_d != state_q) &&
                      ((state_d == S_IF) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR));
   assign tmo_hit   = (MEM_TIMEOUT != 0) && in_mem && !mem_ack && (wait_q == TMO_LIM);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IF;
         fault_q <= 2'd0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         if (enter_mem)
            wait_q <= '0;
         else if (in_mem && !mem_ack && !tmo_hit)
            wait_q <= wait_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      case (state_q)
         S_IF: begin
            if (mem_ack) state_d = S_ID;
            else if (tmo_hit) begin
               state_d = S_TRAP;
               fault_d = FAULT_TMO;
            end
         end
         S_ID: begin
            case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_ADD || funct == FN_ADDU || funct == FN_SUB || funct == FN_SLT)
                     state_d = S_EX_R;
                  else if (funct == FN_JR)
                     state_d = S_JMP;
                  else begin
                     state_d = S_TRAP;
                     fault_d = FAULT_ILLEGAL;
                  end
               end
               OP_ADDI, OP_ADDIU, OP_XORI: state_d = S_EX_I;
               OP_LW, OP_SW:               state_d = S_EX_M;
               OP_BEQ, OP_BNE:             state_d = S_EX_BR;
               OP_J, OP_JAL:               state_d = S_JMP;
               default: begin
                  state_d = S_TRAP;
                  fault_d = FAULT_ILLEGAL;
               end
            endcase
         end
         S_EX_R: state_d = S_WB_R;
         S_EX_I: state_d = S_WB_I;
         S_EX_M: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD, S_MEM_WR: begin
            if (mem_ack) state_d = (state_q == S_MEM_RD) ? S_WB_LW : S_IF;
            else if (tmo_hit) begin
               state_d = S_TRAP;
               fault_d = FAULT_TMO;
            end
         end
         S_EX_BR, S_JMP, S_WB_R, S_WB_I, S_WB_LW: state_d = S_IF;
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_in    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 2'd0;
      pc_src    = 2'd0;
      reg_we    = 1'b0;
      dst       = 2'd0;
      reg_in    = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      alu_op    = 2'd0;
      case (state_q)
         S_IF: begin
            mem_req = 1'b1;
            ir_we   = mem_ack;
            pc_we   = mem_ack ? 2'd1 : 2'd0;
         end
         S_ID: alu_src_b = 2'd3;
         S_EX_R: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd1;
            if (funct == FN_SUB)      alu_op = 2'd1;
            else if (funct == FN_SLT) alu_op = 2'd3;
         end
         S_EX_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = (opcode == OP_XORI) ? 2'd2 : 2'd0;
         end
         S_EX_M: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            mem_in  = 1'b1;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            mem_in  = 1'b1;
         end
         S_EX_BR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd1;
            alu_op    = 2'd1;
            pc_src    = 2'd1;
            pc_we     = (opcode == OP_BNE) ? 2'd3 : 2'd2;
         end
         S_JMP: begin
            pc_we  = 2'd1;
            pc_src = (opcode == OP_RTYPE) ? 2'd2 : 2'd3;
            if (opcode == OP_JAL) begin
               reg_we = 1'b1;
               dst    = 2'd2;
               reg_in = 2'd2;
            end
         end
         S_WB_R: begin
            reg_we = 1'b1;
            dst    = 2'd1;
         end
         S_WB_I:  reg_we = 1'b1;
         S_WB_LW: begin
            reg_we = 1'b1;
            reg_in = 2'd1;
         end
         default: ;
      endcase
      // Nothing may write or request memory while reset is held, whatever state we are in.
      if (reset) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 2'd0;
         reg_we  = 1'b0;
      end
   end

   assign state = state_q;
   assign fault = fault_q;

`ifdef CTRL_PERF_EN
   logic             retire;
   logic [CNT_W-1:0] retired_q;

   assign retire = (state_q == S_EX_BR) || (state_q == S_JMP) || (state_q == S_WB_R) ||
                   (state_q == S_WB_I) || (state_q == S_WB_LW) ||
                   ((state_q == S_MEM_WR) && mem_ack);

   always_ff @(posedge clk) begin
      if (reset)
         retired_q <= '0;
      else if (retire)
         retired_q <= retired_q + 1'b1;
   end

   assign retired = retired_q;
`else
   assign retired = '0;
`endif

endmodule
